load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the DataMemory port, in the MEM stage of the 5-stage RV32I pipeline.
//  Turns one load/store request (funct3 + byte address) into word-indexed memory cycles.
//  Checks alignment and range, then sign/zero-extends loaded data.
//  The memory only writes whole words, so SB/SH are read-modify-write.
//  req_ready stalls the pipeline while an access is in flight.
// PARAMETERS
//  MEM_WORDS   64  number of 32-bit words behind the port; word indices >= MEM_WORDS fault
//  AW          6   mem_addr width, clog2(MEM_WORDS)
// PORTS
//  clk         in   1   single clock; all state updates on posedge
//  reset       in   1   asynchronous, active-high; forces IDLE immediately
//  req_valid   in   1   request present from the EX/MEM register
//  req_write   in   1   1 = store, 0 = load
//  req_funct3  in   3   0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; stores use 0 SB, 1 SH, 2 SW
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data; the low byte/half is used for SB/SH
//  req_ready   out  1   high only in IDLE; a request is accepted when req_valid & req_ready
//  resp_valid  out  1   one-cycle pulse: access complete
//  resp_rdata  out  32  formatted load data; 0 for stores and errors; held until next resp
//  resp_err    out  2   00 ok, 01 misaligned/illegal funct3, 10 out of range; valid with resp_valid
//  mem_read    out  1   DataMemory MemRead
//  mem_write   out  1   DataMemory MemWrite; memory samples it at posedge
//  mem_addr    out  AW  word index, req_addr[AW+1:2]
//  mem_wdata   out  32  DataMemory wr_data
//  mem_rdata   in   32  DataMemory rd_data; combinational, same cycle as mem_read
// BEHAVIOUR
//  Reset values
//   - state = IDLE; resp_valid = 0, resp_rdata = 0, resp_err = 0, all holding registers 0.
//   - mem_read and mem_write are gated to 0 while reset is high.
//  States: IDLE, RMW_RD, RMW_WR, RESP.
//  IDLE, request accepted, error check first:
//   - Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//   - Illegal: load funct3 3/6/7; store funct3 not in {0,1,2}.
//   - Either case: err=01, no mem_* activity, go to RESP.
//   - Else addr[31:2] >= MEM_WORDS: err=10, no mem_* activity, go to RESP.
//   - Misalignment/illegal takes priority over range.
//  IDLE, accepted and legal:
//   - Load: mem_read=1 in the same cycle (Mealy). Extracted lane of mem_rdata is
//     sign- or zero-extended into resp_rdata at the edge. Go to RESP.
//     Latency: 2 cycles accept-to-accept.
//   - SW: mem_write=1 with mem_wdata=req_wdata in the same cycle; go to RESP.
//   - SB/SH: latch addr, byte offset, funct3 and wdata; go to RMW_RD.
//  RMW_RD
//   - mem_read=1 on the latched addr; latch mem_rdata into old_word; go to RMW_WR.
//  RMW_WR
//   - mem_write=1; mem_wdata = old_word with the byte lane (addr[1:0]) or
//     half lane (addr[1]) replaced by wdata[7:0]/[15:0]. Go to RESP.
//   - SB/SH latency: 4 cycles accept-to-accept.
//  RESP
//   - resp_valid=1 for exactly one cycle; go to IDLE. req_ready=0.
//   - A request held during RESP is accepted in the following IDLE cycle.
//  Other rules
//   - mem_read and mem_write are never high in the same cycle.
//   - mem_addr = latched addr outside IDLE; = req_addr[AW+1:2] in IDLE.
//   - Reset during RMW_RD/RMW_WR: mem_write drops immediately, the target word is
//     left unchanged, and there is no resp_valid.
//   - req_* inputs are ignored unless in IDLE.
// STRUCTURE
//  lsu_pkg
//   - funct3 codes (F3_B/H/W/BU/HU), state encoding, ERR_OK/ERR_ALIGN/ERR_RANGE.
//  Sub-module lsu_lane_align (combinational)
//   - Load lane extract plus sign/zero extend.
//   - Store lane merge.
//   - Shared by the IDLE load path and RMW_WR.
//  Top level: FSM, holding registers, error checks, mem_* muxing.
// TESTING
//  Preload word 5 = 32'h8899AABB for every case.
//  1. LB 0x17 -> mem_read one cycle, mem_addr=5; resp_rdata=FFFFFF88, err=00.
//     LBU 0x16 -> 00000099. LH 0x16 -> FFFF8899. LHU 0x14 -> 0000AABB.
//  2. SB 0x15 wdata=0x12 -> RMW_RD, RMW_WR, RESP; word5=889912BB; req_ready low 3 cycles.
//     SH 0x16 wdata=0xCAFE -> word5=CAFEAABB.
//  3. SW 0x14 wdata=DEADBEEF -> single mem_write; word5=DEADBEEF; resp next cycle.
//  4. LW 0x15 -> err=01, no mem_read/mem_write.
//     LW 0x100 -> err=10. LH 0x101 -> err=01 (priority). funct3=3 load -> err=01.
//  5. Reset asserted in RMW_WR of SB 0x14 -> mem_write=0 at once; word5 still 8899AABB;
//     no resp_valid; req_ready=1 after release.
//  6. Back-to-back: LW 0x14 then SB 0x14 with req_valid held ->
//     accepts at cycles 0 and 2; never mem_read&mem_write together.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// response error codes and the alignment/legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  // Illegal funct3 and misalignment both report ERR_ALIGN.
  function automatic logic align_fault(input logic write, input logic [2:0] funct3,
                                       input logic [1:0] off);
    logic fault;
    fault = 1'b1;
    if (write) begin
      case (funct3)
        F3_B:    fault = 1'b0;
        F3_H:    fault = off[0];
        F3_W:    fault = |off;
        default: fault = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: fault = 1'b0;
        F3_H, F3_HU: fault = off[0];
        F3_W:        fault = |off;
        default:     fault = 1'b1;
      endcase
    end
    return fault;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake plus DataMemory port of the load/store unit.
interface lsu_if #(parameter int AW = 6);
  logic          req_valid;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_err;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extract with sign/zero extension and
// store lane merge into a full word for read-modify-write.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b    = word[{off, 3'b000} +: 8];
    lane_h    = off[1] ? word[31:16] : word[15:0];
    load_data = word;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'd0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'd0, lane_h};
      default: load_data = word;
    endcase

    merged = word;
    if (funct3 == F3_B)
      merged[{off, 3'b000} +: 8] = wdata[7:0];
    else if (funct3 == F3_H)
      merged[{off[1], 4'b0000} +: 16] = wdata;
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: error checks, word-indexed DataMemory
// cycles, and read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int AW        = 6
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  state_t        state, state_d;
  logic [AW-1:0] addr_q;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [15:0]   wdata_q;
  logic [31:0]   old_word;
  logic [31:0]   resp_rdata_q;
  logic [1:0]    resp_err_q;

  logic          range_fault;
  logic [1:0]    err_c;
  logic          rd_c, wr_c;
  logic [31:0]   wdata_c;
  logic          idle;
  logic [31:0]   lane_word;
  logic [1:0]    lane_off;
  logic [2:0]    lane_f3;
  logic [31:0]   load_data, merged;

  assign idle        = (state == S_IDLE);
  assign range_fault = (bus.req_addr[31:2] >= 30'(MEM_WORDS));

  // One lane instance serves both the IDLE load path and the RMW merge.
  assign lane_word = idle ? bus.mem_rdata     : old_word;
  assign lane_off  = idle ? bus.req_addr[1:0] : off_q;
  assign lane_f3   = idle ? bus.req_funct3    : f3_q;

  lsu_lane_align u_lane (
    .word      (lane_word),
    .off       (lane_off),
    .funct3    (lane_f3),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d = state;
    rd_c    = 1'b0;
    wr_c    = 1'b0;
    wdata_c = '0;
    err_c   = ERR_OK;
    if (align_fault(bus.req_write, bus.req_funct3, bus.req_addr[1:0]))
      err_c = ERR_ALIGN;
    else if (range_fault)
      err_c = ERR_RANGE;

    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (err_c != ERR_OK) begin
            state_d = S_RESP;
          end else if (!bus.req_write) begin
            rd_c    = 1'b1;
            state_d = S_RESP;
          end else if (bus.req_funct3 == F3_W) begin
            wr_c    = 1'b1;
            wdata_c = bus.req_wdata;
            state_d = S_RESP;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_RMW_RD: begin
        rd_c    = 1'b1;
        state_d = S_RMW_WR;
      end
      S_RMW_WR: begin
        wr_c    = 1'b1;
        wdata_c = merged;
        state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.req_ready  = idle;
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_read   = rd_c & ~reset;
  assign bus.mem_write  = wr_c & ~reset;
  assign bus.mem_addr   = idle ? bus.req_addr[AW+1:2] : addr_q;
  assign bus.mem_wdata  = wdata_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      off_q        <= '0;
      f3_q         <= '0;
      wdata_q      <= '0;
      old_word     <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
    end else begin
      if (idle && bus.req_valid) begin
        addr_q  <= bus.req_addr[AW+1:2];
        off_q   <= bus.req_addr[1:0];
        f3_q    <= bus.req_funct3;
        wdata_q <= bus.req_wdata[15:0];
        if (state_d == S_RESP) begin
          resp_err_q   <= err_c;
          resp_rdata_q <= (err_c == ERR_OK && !bus.req_write) ? load_data : '0;
        end
      end
      if (state == S_RMW_RD)
        old_word <= bus.mem_rdata;
      if (state == S_RMW_WR) begin
        resp_err_q   <= ERR_OK;
        resp_rdata_q <= '0;
      end
    end
  end

endmodule
